checker_ram_writer: RTL and testbench
=====================================

CHECKER_RAM_WRITER -- requirements
Module: checker_ram_writer

Interface
REQ-001 The block SHALL have one parameter: LEN_W, default 16, width of the byte-length field.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid_i, input, 1 bit: a write command is offered.
REQ-005 The block SHALL have port cmd_ready_o, output, 1 bit: a command is accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-006 The block SHALL have ports cmd_addr_i, input, 15 bits (start byte address), and cmd_len_i, input, LEN_W bits (byte count).
REQ-007 The block SHALL have ports dat_valid_i, input, 1 bit; dat_ready_o, output, 1 bit; and dat_i, input, 48 bits: one 6-byte beat, with byte 0 in [7:0].
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a command completes.
REQ-009 The block SHALL have ports ram_adr_0_o..ram_adr_7_o, output, 12 bits each: per-bank word address.
REQ-010 The block SHALL have ports ram_dat_0_o..ram_dat_7_o, output, 8 bits each: per-bank write data.
REQ-011 The block SHALL have ports ram_we_0_o..ram_we_7_o, output, 1 bit each: per-bank write enable.

Function
REQ-012 The RAM SHALL be 8 byte-wide banks; byte address A SHALL map to bank A[2:0], word A[14:3].
REQ-013 The block SHALL implement the FSM states IDLE, DATA and DONE.
- IDLE: cmd_ready_o=1. On accept, latch addr and remaining=cmd_len_i. Go to DATA if len>0, else DONE.
- DATA: dat_ready_o=1. Each accepted beat writes min(6, remaining) bytes, then addr+=that count and remaining-=that count. Go to DONE when remaining reaches 0.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
REQ-014 For a beat at current address A, byte k (k < count) SHALL go to bank (A+k)[2:0] at word (A+k)[14:3], with the corresponding ram_we set.
REQ-015 Banks receiving no byte in a beat SHALL have ram_we=0, ram_adr=0 and ram_dat=0.
REQ-016 Bytes of dat_i at index count and above on the final beat SHALL be ignored.
REQ-017 ram_adr, ram_dat and ram_we SHALL be registered, appearing exactly 1 cycle after the beat handshake.
REQ-018 All ram_we SHALL be 0 in every cycle that does not follow an accepted beat.
REQ-019 Address arithmetic SHALL be modulo 2^15: a beat spanning 0x7FFF->0x0000 writes bank 7 word 0xFFF, then bank 0 word 0x000 in the same cycle.
REQ-020 One beat SHALL touch at most 6 distinct banks with no bank collision.
REQ-021 cmd_ready_o SHALL be 0 outside IDLE, and dat_ready_o SHALL be 0 outside DATA.
REQ-022 Beats offered outside DATA SHALL NOT be consumed, and commands offered outside IDLE SHALL NOT be consumed.
REQ-023 dat_valid_i low in DATA SHALL stall the block with no write and no state change.

Reset
REQ-024 Asserting sys_rst_n low SHALL immediately (asynchronously) force state=IDLE, addr=0, remaining=0, all ram_we/ram_adr/ram_dat=0 and done_o=0.
REQ-025 After reset release, cmd_ready_o SHALL be 1 and dat_ready_o SHALL be 0.
REQ-026 Reset during DATA SHALL abandon the command without a done_o pulse; already-written bytes are not undone.

Configuration
REQ-027 With CHECKER_RAM_WRITER_SUM_EN defined, the block SHALL add output wr_sum_o, 8 bits: XOR of all bytes written since the last command accept.
REQ-028 wr_sum_o SHALL be cleared on command accept and updated in the same cycle the ram_we for those bytes is asserted.
REQ-029 wr_sum_o SHALL be valid when done_o is high, and SHALL reset to 0.
REQ-030 Without CHECKER_RAM_WRITER_SUM_EN, the wr_sum_o port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package checker_ram_pkg SHALL hold: CHK_RAM_BANKS=8, CHK_RAM_BYTE_W=8, CHK_RAM_ADR_W=15, CHK_RAM_WADR_W=12, CHK_BEAT_BYTES=6, and the FSM state enum.
REQ-032 Combinational sub-module checker_ram_lane_map SHALL map (address, count, 48-bit beat) to per-bank we/adr/dat; the top holds the FSM, counters and output registers.

Verification
REQ-033 Aligned: addr 0x0000, len 6, beat 0x060504030201 -> next cycle banks 0..5 we=1, word 0, data 01..06; banks 6,7 we=0; done_o 1 cycle later.
REQ-034 Unaligned wrap: addr 0x0005, len 6 -> banks 5,6,7 word 0 with bytes 0-2; banks 0,1,2 word 1 with bytes 3-5.
REQ-035 Space wrap: addr 0x7FFE, len 6 -> banks 6,7 word 0xFFF; banks 0..3 word 0x000.
REQ-036 Multi-beat partial: addr 0x0010, len 8, 2 beats -> second beat writes only banks 6,7 (addr 0x0016, 0x0017); beat bytes 2-5 ignored; done_o after beat 2.
REQ-037 Zero length: len 0 -> no ram_we ever; done_o high 2 cycles after accept; dat_ready_o stays 0.
REQ-038 Stall and reset: dat_valid_i low 3 cycles mid-command -> no writes during the stall; sys_rst_n low mid-DATA -> outputs 0 at once, no done_o, IDLE after release.

Source files
------------

// File: rtl/checker_ram_pkg.sv
// checker_ram_pkg: shared geometry constants and FSM state type for the banked RAM writer.
// No ports; imported by checker_ram_lane_map and checker_ram_writer.
package checker_ram_pkg;
    localparam int CHK_RAM_BANKS  = 8;
    localparam int CHK_RAM_BYTE_W = 8;
    localparam int CHK_RAM_ADR_W  = 15;
    localparam int CHK_RAM_WADR_W = 12;
    localparam int CHK_BEAT_BYTES = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DONE} chk_state_t;
endpackage

// File: rtl/checker_ram_lane_map.sv
// checker_ram_lane_map: steers the bytes of one beat onto the 8 byte-wide RAM banks.
// Ports: addr  - byte address of beat byte 0
//        cnt   - number of valid bytes in the beat (0..6)
//        beat  - 6-byte beat, byte 0 in [7:0]
//        we/adr/dat - per-bank write enable, word address and data; unused banks all-zero
module checker_ram_lane_map
    import checker_ram_pkg::*;
(
    input  logic [CHK_RAM_ADR_W-1:0]                         addr,
    input  logic [2:0]                                       cnt,
    input  logic [CHK_BEAT_BYTES*CHK_RAM_BYTE_W-1:0]         beat,
    output logic [CHK_RAM_BANKS-1:0]                         we,
    output logic [CHK_RAM_BANKS-1:0][CHK_RAM_WADR_W-1:0]     adr,
    output logic [CHK_RAM_BANKS-1:0][CHK_RAM_BYTE_W-1:0]     dat
);
    logic [CHK_RAM_BANKS*CHK_RAM_BYTE_W-1:0] beat_x;
    assign beat_x = {{((CHK_RAM_BANKS-CHK_BEAT_BYTES)*CHK_RAM_BYTE_W){1'b0}}, beat};
    // Each bank owns exactly one beat offset k = bank - addr (mod 8); since a beat
    // carries at most 6 bytes, no two bytes ever land in the same bank.
    for (genvar b = 0; b < CHK_RAM_BANKS; b++) begin : g_bank
        logic [2:0]               k;
        logic [CHK_RAM_ADR_W-1:0] a;
        assign k      = 3'(b) - addr[2:0];
        assign a      = addr + CHK_RAM_ADR_W'(k);
        assign we[b]  = k < cnt;
        assign adr[b] = we[b] ? a[CHK_RAM_ADR_W-1:3] : '0;
        assign dat[b] = we[b] ? beat_x[{k, 3'b000} +: CHK_RAM_BYTE_W] : '0;
    end
endmodule

// File: rtl/checker_ram_writer.sv
// checker_ram_writer: writes a byte-addressed command of cmd_len_i bytes, fed as 6-byte beats,
// into 8 byte-wide RAM banks (byte A -> bank A[2:0], word A[14:3]).
// Ports: sys_clk / sys_rst_n (async active-low)
//        cmd_valid_i/cmd_ready_o/cmd_addr_i/cmd_len_i - command handshake
//        dat_valid_i/dat_ready_o/dat_i                - beat handshake
//        done_o                                       - one-cycle completion pulse
//        ram_{adr,dat,we}_{0..7}_o                    - registered per-bank write port
//        wr_sum_o (only with CHECKER_RAM_WRITER_SUM_EN) - XOR of bytes written this command
module checker_ram_writer
    import checker_ram_pkg::*;
#(
    parameter int LEN_W = 16
)
(
`ifdef CHECKER_RAM_WRITER_SUM_EN
    output logic [CHK_RAM_BYTE_W-1:0]                 wr_sum_o,
`endif
    input  logic                                      sys_clk,
    input  logic                                      sys_rst_n,
    input  logic                                      cmd_valid_i,
    output logic                                      cmd_ready_o,
    input  logic [CHK_RAM_ADR_W-1:0]                  cmd_addr_i,
    input  logic [LEN_W-1:0]                          cmd_len_i,
    input  logic                                      dat_valid_i,
    output logic                                      dat_ready_o,
    input  logic [CHK_BEAT_BYTES*CHK_RAM_BYTE_W-1:0]  dat_i,
    output logic                                      done_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_0_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_1_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_2_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_3_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_4_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_5_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_6_o,
    output logic [CHK_RAM_WADR_W-1:0]                 ram_adr_7_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_0_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_1_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_2_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_3_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_4_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_5_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_6_o,
    output logic [CHK_RAM_BYTE_W-1:0]                 ram_dat_7_o,
    output logic                                      ram_we_0_o,
    output logic                                      ram_we_1_o,
    output logic                                      ram_we_2_o,
    output logic                                      ram_we_3_o,
    output logic                                      ram_we_4_o,
    output logic                                      ram_we_5_o,
    output logic                                      ram_we_6_o,
    output logic                                      ram_we_7_o
);
    chk_state_t                                      state, state_nx;
    logic [CHK_RAM_ADR_W-1:0]                        addr;
    logic [LEN_W-1:0]                                remaining;
    logic [2:0]                                      cnt;
    logic                                            cmd_acc, beat_acc;
    logic [CHK_RAM_BANKS-1:0]                        lane_we, we_q;
    logic [CHK_RAM_BANKS-1:0][CHK_RAM_WADR_W-1:0]    lane_adr, adr_q;
    logic [CHK_RAM_BANKS-1:0][CHK_RAM_BYTE_W-1:0]    lane_dat, dat_q;

    assign cnt      = (remaining >= LEN_W'(CHK_BEAT_BYTES)) ? 3'(CHK_BEAT_BYTES) : remaining[2:0];
    assign cmd_acc  = cmd_valid_i && state == ST_IDLE;
    assign beat_acc = dat_valid_i && state == ST_DATA;

    checker_ram_lane_map u_lane_map (
        .addr (addr),
        .cnt  (cnt),
        .beat (dat_i),
        .we   (lane_we),
        .adr  (lane_adr),
        .dat  (lane_dat)
    );

    always_comb begin
        cmd_ready_o = state == ST_IDLE;
        dat_ready_o = state == ST_DATA;
        state_nx    = state == ST_IDLE ? (cmd_acc ? (cmd_len_i == '0 ? ST_DONE : ST_DATA) : ST_IDLE) :
                      state == ST_DATA ? ((beat_acc && remaining == LEN_W'(cnt)) ? ST_DONE : ST_DATA) :
                      ST_IDLE;
    end

    // done_o is registered from the DONE state so it trails the final write by one cycle,
    // which is also when the running write checksum has absorbed the last beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            done_o    <= 1'b0;
            we_q      <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state  <= state_nx;
            done_o <= state == ST_DONE;
            if (cmd_acc) begin
                addr      <= cmd_addr_i;
                remaining <= cmd_len_i;
            end else if (beat_acc) begin
                addr      <= addr + CHK_RAM_ADR_W'(cnt);
                remaining <= remaining - LEN_W'(cnt);
            end
            we_q  <= beat_acc ? lane_we : '0;
            adr_q <= beat_acc ? lane_adr : '0;
            dat_q <= beat_acc ? lane_dat : '0;
        end
    end

`ifdef CHECKER_RAM_WRITER_SUM_EN
    logic [CHK_RAM_BYTE_W-1:0] lane_xor;
    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < CHK_RAM_BANKS; i++) lane_xor = lane_xor ^ lane_dat[i];
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) wr_sum_o <= '0;
        else            wr_sum_o <= cmd_acc ? '0 : beat_acc ? wr_sum_o ^ lane_xor : wr_sum_o;
    end
`endif

    assign {ram_we_7_o, ram_we_6_o, ram_we_5_o, ram_we_4_o,
            ram_we_3_o, ram_we_2_o, ram_we_1_o, ram_we_0_o} = we_q;
    assign ram_adr_0_o = adr_q[0];
    assign ram_adr_1_o = adr_q[1];
    assign ram_adr_2_o = adr_q[2];
    assign ram_adr_3_o = adr_q[3];
    assign ram_adr_4_o = adr_q[4];
    assign ram_adr_5_o = adr_q[5];
    assign ram_adr_6_o = adr_q[6];
    assign ram_adr_7_o = adr_q[7];
    assign ram_dat_0_o = dat_q[0];
    assign ram_dat_1_o = dat_q[1];
    assign ram_dat_2_o = dat_q[2];
    assign ram_dat_3_o = dat_q[3];
    assign ram_dat_4_o = dat_q[4];
    assign ram_dat_5_o = dat_q[5];
    assign ram_dat_6_o = dat_q[6];
    assign ram_dat_7_o = dat_q[7];
endmodule

// File: tb/tb_checker_ram_writer.sv
// tb_checker_ram_writer: randomized self-checking bench for checker_ram_writer against a byte-level model.
module tb_checker_ram_writer;
    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic [14:0]      cmd_addr_i = '0;
    logic [15:0]      cmd_len_i = '0;
    logic             dat_valid_i = 1'b0;
    logic [47:0]      dat_i = '0;
    logic             cmd_ready_o, dat_ready_o, done_o;
    logic [7:0]       we;
    logic [7:0][11:0] adr;
    logic [7:0][7:0]  dat;
`ifdef CHECKER_RAM_WRITER_SUM_EN
    logic [7:0]       wr_sum_o;
`endif
    int               nvec = 0;
    int               nerr = 0;
    logic [47:0]      beat_q[$];

    checker_ram_writer #(.LEN_W(16)) dut (
`ifdef CHECKER_RAM_WRITER_SUM_EN
        .wr_sum_o    (wr_sum_o),
`endif
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .dat_valid_i (dat_valid_i),
        .dat_ready_o (dat_ready_o),
        .dat_i       (dat_i),
        .done_o      (done_o),
        .ram_adr_0_o (adr[0]), .ram_adr_1_o (adr[1]), .ram_adr_2_o (adr[2]), .ram_adr_3_o (adr[3]),
        .ram_adr_4_o (adr[4]), .ram_adr_5_o (adr[5]), .ram_adr_6_o (adr[6]), .ram_adr_7_o (adr[7]),
        .ram_dat_0_o (dat[0]), .ram_dat_1_o (dat[1]), .ram_dat_2_o (dat[2]), .ram_dat_3_o (dat[3]),
        .ram_dat_4_o (dat[4]), .ram_dat_5_o (dat[5]), .ram_dat_6_o (dat[6]), .ram_dat_7_o (dat[7]),
        .ram_we_0_o  (we[0]),  .ram_we_1_o  (we[1]),  .ram_we_2_o  (we[2]),  .ram_we_3_o  (we[3]),
        .ram_we_4_o  (we[4]),  .ram_we_5_o  (we[5]),  .ram_we_6_o  (we[6]),  .ram_we_7_o  (we[7])
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-level model: every byte k of the beat lands at byte address (a+k) mod 2^15.
    task automatic beat_exp(input logic [14:0] a, input int cnt, input logic [47:0] d,
                            output logic [7:0] ew, output logic [7:0][11:0] ea, output logic [7:0][7:0] ed);
        int ba;
        ew = '0;
        ea = '0;
        ed = '0;
        for (int k = 0; k < cnt; k++) begin
            ba = (int'(a) + k) % 32768;
            ew[ba % 8] = 1'b1;
            ea[ba % 8] = 12'(ba / 8);
            ed[ba % 8] = d[8*k +: 8];
        end
    endtask

    task automatic run_cmd(input logic [14:0] a, input int len, input int min_stall, input int max_stall);
        logic [14:0]      cur;
        int               rem, cnt, s;
        logic [47:0]      d;
        logic [7:0]       ew, sum;
        logic [7:0][11:0] ea;
        logic [7:0][7:0]  ed;
        @(negedge sys_clk);
        check("cmd_ready_idle", cmd_ready_o, 1'b1);
        check("dat_ready_idle", dat_ready_o, 1'b0);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_len_i   = 16'(len);
        @(posedge sys_clk); #1;
        cmd_valid_i = 1'b0;
        check("cmd_ready_busy", cmd_ready_o, 1'b0);
        check("we_after_cmd", we, 8'h00);
        check("dat_ready_after_cmd", dat_ready_o, len > 0);
        check("done_after_cmd", done_o, 1'b0);
        cur = a;
        rem = len;
        sum = '0;
        if (len > 0) begin
            cmd_valid_i = 1'b1;
            cmd_addr_i  = 15'($urandom);
            cmd_len_i   = 16'($urandom);
        end
        while (rem > 0) begin
            s = int'($urandom_range(max_stall, min_stall));
            repeat (s) begin
                @(posedge sys_clk); #1;
                check("stall_we", we, 8'h00);
                check("stall_dat_ready", dat_ready_o, 1'b1);
            end
            d   = (beat_q.size() > 0) ? beat_q.pop_front() : 48'({$urandom(), $urandom()});
            cnt = rem < 6 ? rem : 6;
            dat_i       = d;
            dat_valid_i = 1'b1;
            @(posedge sys_clk); #1;
            dat_valid_i = 1'b0;
            dat_i       = 48'({$urandom(), $urandom()});
            beat_exp(cur, cnt, d, ew, ea, ed);
            check("beat_we", we, ew);
            check("beat_adr", adr, ea);
            check("beat_dat", dat, ed);
            check("done_early", done_o, 1'b0);
            for (int k = 0; k < cnt; k++) sum = sum ^ d[8*k +: 8];
            cur = cur + 15'(cnt);
            rem = rem - cnt;
            check("dat_ready_after_beat", dat_ready_o, rem > 0);
        end
        cmd_valid_i = 1'b0;
        dat_valid_i = 1'b1;
        @(posedge sys_clk); #1;
        check("done_pulse", done_o, 1'b1);
        check("done_we", we, 8'h00);
        check("done_dat_ready", dat_ready_o, 1'b0);
`ifdef CHECKER_RAM_WRITER_SUM_EN
        check("wr_sum", wr_sum_o, sum);
`endif
        @(posedge sys_clk); #1;
        dat_valid_i = 1'b0;
        check("done_once", done_o, 1'b0);
        check("idle_we", we, 8'h00);
    endtask

    initial begin
        logic [14:0] ra;
        #1;
        check("rst_we", we, 8'h00);
        check("rst_adr", adr, '0);
        check("rst_dat", dat, '0);
        check("rst_done", done_o, 1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_dat_ready", dat_ready_o, 1'b0);
        dat_valid_i = 1'b1;
        dat_i       = 48'hFFFF_FFFF_FFFF;
        repeat (2) begin
            @(posedge sys_clk); #1;
            check("idle_beat_ignored", we, 8'h00);
        end
        dat_valid_i = 1'b0;

        beat_q.push_back(48'h060504030201);
        run_cmd(15'h0000, 6, 0, 0);
        run_cmd(15'h0005, 6, 0, 1);
        run_cmd(15'h7FFE, 6, 0, 0);
        run_cmd(15'h0010, 8, 0, 0);
        run_cmd(15'h0123, 0, 0, 0);
        run_cmd(15'h0040, 18, 3, 3);

        @(negedge sys_clk);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 15'h0100;
        cmd_len_i   = 16'd20;
        @(posedge sys_clk); #1;
        cmd_valid_i = 1'b0;
        dat_i       = 48'h0A0B0C0D0E0F;
        dat_valid_i = 1'b1;
        @(posedge sys_clk); #1;
        dat_valid_i = 1'b0;
        check("pre_rst_we", we, 8'h3F);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_we", we, 8'h00);
        check("arst_adr", adr, '0);
        check("arst_dat", dat, '0);
        check("arst_done", done_o, 1'b0);
        check("arst_cmd_ready", cmd_ready_o, 1'b1);
        check("arst_dat_ready", dat_ready_o, 1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(posedge sys_clk); #1;
            check("post_rst_done", done_o, 1'b0);
            check("post_rst_cmd_ready", cmd_ready_o, 1'b1);
        end

        repeat (40) begin
            ra = ($urandom_range(3, 0) == 0) ? 15'(15'h7FF0 + $urandom_range(15, 0)) : 15'($urandom);
            run_cmd(ra, int'($urandom_range(30, 0)), 0, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
